// File: rtl/kmeans_iter_ctrl.sv
// -----------------------------------------------------------------------------
// kmeans_iter_ctrl
// Iteration controller for a k-means clustering engine. It sequences one run:
// load the active centroid registers, stream the point range from RAM through
// the classification pipe, drain the pipe, divide, wait for the convergence
// verdict, and either iterate again or write the centroids back.
//
// Every output is registered and reflects the state the FSM is in this cycle.
// The output register is loaded from the *next* state and next counters, so
// a transition and its strobes appear in the same cycle.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   go                           start pulse, only looked at in IDLE
//   abort                        terminate the run (status 11)
//   k_m1                         number of active centroids minus one
//   first_addr, last_addr        inclusive RAM point range
//   max_iter                     iteration cap (0 = unlimited)
//   conv_valid, has_converged    convergence verdict strobe and value
//   reg_num, reg_write           register-file index and write strobe
//   cent_en                      one-hot centroid-register enable
//   ram_addr, ram_cs_n, ram_oe_n RAM address and active-low controls
//   acc_en, pipe_clr, first_iter, div_en, conv_en, conv_clr  datapath controls
//   busy, done, status, iter_cnt run status
//
// Build option
//   KMEANS_ITER_LIMIT_EN : when defined, max_iter caps the iteration count
//                          (status 10). When undefined, max_iter is ignored.
// -----------------------------------------------------------------------------
module kmeans_iter_ctrl #(
  parameter int CENT_NUM      = 8,
  parameter int LOG2_CENT_NUM = 3,
  parameter int ADDR_W        = 9,
  parameter int PIPE_DEPTH    = 3,
  parameter int ITER_W        = 8,
  parameter int REG_W         = 4,
  parameter int CENT_REG_BASE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     abort,
  input  logic [LOG2_CENT_NUM-1:0] k_m1,
  input  logic [ADDR_W-1:0]        first_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic                     conv_valid,
  input  logic                     has_converged,
  output logic [REG_W-1:0]         reg_num,
  output logic                     reg_write,
  output logic [CENT_NUM-1:0]      cent_en,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_cs_n,
  output logic                     ram_oe_n,
  output logic                     acc_en,
  output logic                     pipe_clr,
  output logic                     first_iter,
  output logic                     div_en,
  output logic                     conv_en,
  output logic                     conv_clr,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic [ITER_W-1:0]        iter_cnt
);

  // The centroid index needs one extra bit to represent k_m1+1 (end of walk).
  localparam int IDX_W = LOG2_CENT_NUM + 1;
  localparam int CNT_W = 3;

  localparam logic [IDX_W-1:0]    IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    PIPE_LAST = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0]   ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0]   ITER_MAX  = {ITER_W{1'b1}};
  localparam logic [CENT_NUM-1:0] CENT_ONE  = {{(CENT_NUM-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0]    REG_BASE  = REG_W'(CENT_REG_BASE);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_CENT = 4'd1,
    S_FILL      = 4'd2,
    S_CLASSIFY  = 4'd3,
    S_DRAIN     = 4'd4,
    S_CALC      = 4'd5,
    S_CONV_WAIT = 4'd6,
    S_WRITEBACK = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [IDX_W-1:0]           idx_r, idx_nxt_s;
  logic [CNT_W-1:0]           cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0]          addr_r, addr_nxt_s;
  logic [LOG2_CENT_NUM-1:0]   k_r, k_nxt_s;
  logic [ADDR_W-1:0]          first_r, first_nxt_s;
  logic [ADDR_W-1:0]          last_r, last_nxt_s;
  logic [1:0]                 status_nxt_s;
  logic [ITER_W-1:0]          iter_nxt_s, iter_inc_s;
  logic                       first_iter_nxt_s;
  logic                       abort_hit_s;
  logic                       limit_hit_s;
  logic [IDX_W-1:0]           k_p1_s;
  logic [IDX_W-1:0]           k_nxt_ext_s;

  logic [REG_W-1:0]           reg_num_s;
  logic                       reg_write_s;
  logic [CENT_NUM-1:0]        cent_en_s;
  logic [ADDR_W-1:0]          ram_addr_s;
  logic                       ram_cs_n_s, ram_oe_n_s;
  logic                       acc_en_s, pipe_clr_s, div_en_s;
  logic                       conv_en_s, conv_clr_s, busy_s, done_s;

  // Abort ends any active run; DONE is already terminating and ignores it.
  assign abort_hit_s = abort && (state_r != S_IDLE) && (state_r != S_DONE);
  assign k_p1_s      = {1'b0, k_r} + IDX_ONE;
  assign k_nxt_ext_s = {1'b0, k_nxt_s};
  // iter_cnt saturates instead of wrapping.
  assign iter_inc_s  = (iter_cnt == ITER_MAX) ? iter_cnt : (iter_cnt + ITER_ONE);

`ifdef KMEANS_ITER_LIMIT_EN
  logic [ITER_W-1:0] max_r;

  // Capture the iteration cap at start of run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r <= {ITER_W{1'b0}};
    end else if ((state_r == S_IDLE) && go) begin
      max_r <= max_iter;
    end else begin
      max_r <= max_r;
    end
  end

  assign limit_hit_s = (max_r != {ITER_W{1'b0}}) && (iter_inc_s == max_r);
`else
  // The cap is ignored in this build; the reduction only marks the port used.
  logic unused_max_iter_s;
  assign unused_max_iter_s = ^max_iter;
  assign limit_hit_s       = 1'b0;
`endif

  // Next-state and run-context computation.
  always_comb begin
    state_nxt_s      = state_r;
    idx_nxt_s        = idx_r;
    cnt_nxt_s        = cnt_r;
    addr_nxt_s       = addr_r;
    k_nxt_s          = k_r;
    first_nxt_s      = first_r;
    last_nxt_s       = last_r;
    status_nxt_s     = status;
    iter_nxt_s       = iter_cnt;
    first_iter_nxt_s = first_iter;
    if (abort_hit_s) begin
      state_nxt_s  = S_DONE;
      status_nxt_s = 2'b11;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            state_nxt_s      = S_LOAD_CENT;
            k_nxt_s          = k_m1;
            first_nxt_s      = first_addr;
            last_nxt_s       = last_addr;
            idx_nxt_s        = IDX_ZERO;
            status_nxt_s     = 2'b00;
            iter_nxt_s       = {ITER_W{1'b0}};
            first_iter_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        // idx 0..k_m1 issues reg_num; idx 1..k_m1+1 issues the delayed cent_en.
        S_LOAD_CENT: begin
          if (idx_r == k_p1_s) begin
            if (first_r > last_r) begin
              state_nxt_s  = S_DONE;
              status_nxt_s = 2'b11;
            end else begin
              state_nxt_s = S_FILL;
              cnt_nxt_s   = CNT_ZERO;
              addr_nxt_s  = first_r;
            end
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end
        // A range shorter than the pipe finishes its reads while still filling.
        S_FILL: begin
          if (addr_r == last_r) begin
            state_nxt_s = S_DRAIN;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == PIPE_LAST) begin
            state_nxt_s = S_CLASSIFY;
            addr_nxt_s  = addr_r + ADDR_ONE;
          end else begin
            addr_nxt_s = addr_r + ADDR_ONE;
            cnt_nxt_s  = cnt_r + CNT_ONE;
          end
        end
        S_CLASSIFY: begin
          if (addr_r == last_r) begin
            state_nxt_s = S_DRAIN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            addr_nxt_s = addr_r + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (cnt_r == PIPE_LAST) begin
            state_nxt_s = S_CALC;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        S_CALC: begin
          state_nxt_s = S_CONV_WAIT;
          idx_nxt_s   = IDX_ZERO;
        end
        // idx walks the centroid enables and parks at k_m1+1 (all enables off).
        S_CONV_WAIT: begin
          if (conv_valid) begin
            iter_nxt_s = iter_inc_s;
            if (has_converged) begin
              state_nxt_s  = S_WRITEBACK;
              status_nxt_s = 2'b01;
              idx_nxt_s    = IDX_ZERO;
            end else if (limit_hit_s) begin
              state_nxt_s  = S_WRITEBACK;
              status_nxt_s = 2'b10;
              idx_nxt_s    = IDX_ZERO;
            end else begin
              state_nxt_s      = S_FILL;
              first_iter_nxt_s = 1'b0;
              addr_nxt_s       = first_r;
              cnt_nxt_s        = CNT_ZERO;
            end
          end else if (idx_r != k_p1_s) begin
            idx_nxt_s = idx_r + IDX_ONE;
          end else begin
            idx_nxt_s = idx_r;
          end
        end
        S_WRITEBACK: begin
          if (idx_r == {1'b0, k_r}) begin
            state_nxt_s = S_DONE;
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end
        S_DONE: begin
          state_nxt_s = S_IDLE;
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Output values for the state being entered.
  always_comb begin
    reg_num_s   = {REG_W{1'b0}};
    reg_write_s = 1'b0;
    cent_en_s   = {CENT_NUM{1'b0}};
    ram_addr_s  = {ADDR_W{1'b0}};
    ram_cs_n_s  = 1'b1;
    ram_oe_n_s  = 1'b1;
    acc_en_s    = 1'b0;
    pipe_clr_s  = 1'b0;
    div_en_s    = 1'b0;
    conv_en_s   = 1'b0;
    conv_clr_s  = 1'b0;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    case (state_nxt_s)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_LOAD_CENT: begin
        if (idx_nxt_s <= k_nxt_ext_s) begin
          reg_num_s = REG_BASE + REG_W'(idx_nxt_s);
        end else begin
          reg_num_s = {REG_W{1'b0}};
        end
        if (idx_nxt_s != IDX_ZERO) begin
          cent_en_s = CENT_ONE << (idx_nxt_s - IDX_ONE);
        end else begin
          cent_en_s = {CENT_NUM{1'b0}};
        end
      end
      S_FILL: begin
        ram_cs_n_s = 1'b0;
        ram_oe_n_s = 1'b0;
        ram_addr_s = addr_nxt_s;
        pipe_clr_s = (cnt_nxt_s == CNT_ZERO);
      end
      S_CLASSIFY: begin
        ram_cs_n_s = 1'b0;
        ram_oe_n_s = 1'b0;
        ram_addr_s = addr_nxt_s;
        acc_en_s   = 1'b1;
      end
      S_DRAIN: begin
        acc_en_s = 1'b1;
      end
      S_CALC: begin
        div_en_s   = 1'b1;
        conv_clr_s = 1'b1;
      end
      S_CONV_WAIT: begin
        conv_en_s = 1'b1;
        if (idx_nxt_s <= k_nxt_ext_s) begin
          cent_en_s = CENT_ONE << idx_nxt_s;
        end else begin
          cent_en_s = {CENT_NUM{1'b0}};
        end
      end
      S_WRITEBACK: begin
        reg_write_s = 1'b1;
        reg_num_s   = REG_BASE + REG_W'(idx_nxt_s);
      end
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, run context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      idx_r      <= IDX_ZERO;
      cnt_r      <= CNT_ZERO;
      addr_r     <= {ADDR_W{1'b0}};
      k_r        <= {LOG2_CENT_NUM{1'b0}};
      first_r    <= {ADDR_W{1'b0}};
      last_r     <= {ADDR_W{1'b0}};
      status     <= 2'b00;
      iter_cnt   <= {ITER_W{1'b0}};
      first_iter <= 1'b1;
      reg_num    <= {REG_W{1'b0}};
      reg_write  <= 1'b0;
      cent_en    <= {CENT_NUM{1'b0}};
      ram_addr   <= {ADDR_W{1'b0}};
      ram_cs_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      acc_en     <= 1'b0;
      pipe_clr   <= 1'b0;
      div_en     <= 1'b0;
      conv_en    <= 1'b0;
      conv_clr   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      addr_r     <= addr_nxt_s;
      k_r        <= k_nxt_s;
      first_r    <= first_nxt_s;
      last_r     <= last_nxt_s;
      status     <= status_nxt_s;
      iter_cnt   <= iter_nxt_s;
      first_iter <= first_iter_nxt_s;
      reg_num    <= reg_num_s;
      reg_write  <= reg_write_s;
      cent_en    <= cent_en_s;
      ram_addr   <= ram_addr_s;
      ram_cs_n   <= ram_cs_n_s;
      ram_oe_n   <= ram_oe_n_s;
      acc_en     <= acc_en_s;
      pipe_clr   <= pipe_clr_s;
      div_en     <= div_en_s;
      conv_en    <= conv_en_s;
      conv_clr   <= conv_clr_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for kmeans_iter_ctrl. Each run is summarised as ordered event
// lists (centroid loads, enable walks, RAM addresses, write-backs) and counts,
// which are compared with lists built directly from the run parameters.
// -----------------------------------------------------------------------------
module tb_kmeans_iter_ctrl;

  localparam int P    = 3;
  localparam int BASE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       abort;
  logic [2:0] k_m1;
  logic [8:0] first_addr;
  logic [8:0] last_addr;
  logic [7:0] max_iter;
  logic       conv_valid;
  logic       has_converged;
  logic [3:0] reg_num;
  logic       reg_write;
  logic [7:0] cent_en;
  logic [8:0] ram_addr;
  logic       ram_cs_n, ram_oe_n;
  logic       acc_en, pipe_clr, first_iter, div_en, conv_en, conv_clr;
  logic       busy, done;
  logic [1:0] status;
  logic [7:0] iter_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  kmeans_iter_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .k_m1(k_m1),
    .first_addr(first_addr), .last_addr(last_addr), .max_iter(max_iter),
    .conv_valid(conv_valid), .has_converged(has_converged),
    .reg_num(reg_num), .reg_write(reg_write), .cent_en(cent_en),
    .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
    .acc_en(acc_en), .pipe_clr(pipe_clr), .first_iter(first_iter),
    .div_en(div_en), .conv_en(conv_en), .conv_clr(conv_clr),
    .busy(busy), .done(done), .status(status), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    check({tag, "_seq"}, {31'd0, q_eq(got, exp)}, 32'd1);
  endtask

  // mode 0: normal run, 1: abort in CLASSIFY, 2: reset in CONV_WAIT
  task automatic run_case(input string name, input int k, input int fa, input int la,
                          input int conv_iter, input int maxi, input int mode);
    int  load_q[$], ldreg_q[$], walk_q[$], wb_q[$], addr_q[$], fi_q[$];
    int  e_load[$], e_ldreg[$], e_walk[$], e_wb[$], e_addr[$], e_fi[$];
    int  acc_mem = 0, acc_dr = 0, pclr = 0, divc = 0, cclr = 0, oe_bad = 0;
    int  nconv = 0, wc = 0, wdelay, iters, est, n, late_done;
    bit  seen_done = 0, aborted = 0, abort_pend = 0;
    wdelay = k + 1 + $urandom_range(0, 2);
    @(negedge clk);
    k_m1 = k[2:0]; first_addr = fa[8:0]; last_addr = la[8:0]; max_iter = maxi[7:0];
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (abort_pend) begin
        check({name, "_abort_done"}, {31'd0, done}, 32'd1);
        check({name, "_abort_cs_n"}, {31'd0, ram_cs_n}, 32'd1);
        check({name, "_abort_acc"}, {31'd0, acc_en}, 32'd0);
        check({name, "_abort_status"}, {30'd0, status}, 32'd3);
        abort = 1'b0;
        abort_pend = 1'b0;
      end
      if (ram_oe_n !== ram_cs_n) oe_bad++;
      if (cent_en != 8'd0 && !conv_en) load_q.push_back(int'(cent_en));
      if (cent_en != 8'd0 && conv_en) walk_q.push_back(int'(cent_en));
      if (reg_num != 4'd0 && !reg_write) ldreg_q.push_back(int'(reg_num));
      if (reg_write) wb_q.push_back(int'(reg_num));
      if (!ram_cs_n) addr_q.push_back(int'(ram_addr));
      if (acc_en && !ram_cs_n) acc_mem++;
      if (acc_en && ram_cs_n) acc_dr++;
      if (pipe_clr) begin pclr++; fi_q.push_back(int'(first_iter)); end
      if (div_en) divc++;
      if (conv_clr) cclr++;
      if (done) begin
        seen_done = 1'b1;
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
      if (mode == 2 && conv_en && wc == 1) begin
        go = 1'b0; conv_valid = 1'b0; has_converged = 1'b0;
        rst = 1'b1;
        #1;
        check({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_rst_conv_en"}, {31'd0, conv_en}, 32'd0);
        check({name, "_rst_cs_n"}, {31'd0, ram_cs_n}, 32'd1);
        check({name, "_rst_first_iter"}, {31'd0, first_iter}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        repeat (6) begin
          @(negedge clk);
          if (done || busy) late_done++;
        end
        check({name, "_no_done_after_rst"}, late_done, 0);
        return;
      end
      conv_valid = 1'b0;
      has_converged = 1'b0;
      if (conv_en) begin
        if (wc == wdelay) begin
          conv_valid = 1'b1;
          has_converged = (nconv + 1 == conv_iter);
          nconv++;
          wc = 0;
          wdelay = k + 1 + $urandom_range(0, 2);
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
      end
      if (mode == 1 && !aborted && acc_en && !ram_cs_n) begin
        abort = 1'b1; aborted = 1'b1; abort_pend = 1'b1;
      end
      go = (busy && !done) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (!seen_done) @(negedge clk);
    end
    go = 1'b0; abort = 1'b0; conv_valid = 1'b0; has_converged = 1'b0;
    check({name, "_done_seen"}, {31'd0, seen_done}, 32'd1);
    check({name, "_oe_follows_cs"}, oe_bad, 0);
    for (int i = 0; i <= k; i++) begin
      e_load.push_back(1 << i);
      e_ldreg.push_back(BASE + i);
    end
    check_q({name, "_load_cent"}, load_q, e_load);
    check_q({name, "_load_reg"}, ldreg_q, e_ldreg);
    if (mode == 1) begin
      check({name, "_status"}, {30'd0, status}, 32'd3);
      check({name, "_iter"}, {24'd0, iter_cnt}, 32'd0);
      check({name, "_wb_none"}, wb_q.size(), 0);
      check({name, "_drain_none"}, acc_dr, 0);
    end else begin
      if (fa > la) begin
        iters = 0; est = 3;
      end else begin
        iters = conv_iter; est = 1;
`ifdef KMEANS_ITER_LIMIT_EN
        if (maxi != 0 && maxi < conv_iter) begin iters = maxi; est = 2; end
`endif
        for (int i = 0; i <= k; i++) e_wb.push_back(BASE + i);
      end
      n = (fa > la) ? 0 : (la - fa + 1);
      for (int it = 0; it < iters; it++) begin
        for (int a = fa; a <= la; a++) e_addr.push_back(a);
        for (int i = 0; i <= k; i++) e_walk.push_back(1 << i);
        e_fi.push_back(it == 0 ? 1 : 0);
      end
      check({name, "_status"}, {30'd0, status}, est);
      check({name, "_iter"}, {24'd0, iter_cnt}, iters);
      check_q({name, "_ram_addr"}, addr_q, e_addr);
      check_q({name, "_walk"}, walk_q, e_walk);
      check_q({name, "_writeback"}, wb_q, e_wb);
      check_q({name, "_first_iter"}, fi_q, e_fi);
      check({name, "_acc_mem"}, acc_mem, iters * ((n > P) ? (n - P) : 0));
      check({name, "_acc_drain"}, acc_dr, iters * P);
      check({name, "_pipe_clr"}, pclr, iters);
      check({name, "_div_en"}, divc, iters);
      check({name, "_conv_clr"}, cclr, iters);
      est = int'(status);
    end
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({name, "_status_hold"}, {30'd0, status}, (mode == 1) ? 3 : est);
  endtask

  initial begin
    int fa, la;
    rst = 1'b1; go = 1'b0; abort = 1'b0; k_m1 = 3'd0; first_addr = 9'd0;
    last_addr = 9'd0; max_iter = 8'd0; conv_valid = 1'b0; has_converged = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cs_n", {31'd0, ram_cs_n}, 32'd1);
    check("reset_oe_n", {31'd0, ram_oe_n}, 32'd1);
    check("reset_first_iter", {31'd0, first_iter}, 32'd1);
    check("reset_status", {30'd0, status}, 32'd0);
    check("reset_iter", {24'd0, iter_cnt}, 32'd0);
    check("reset_cent_en", {24'd0, cent_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_case("k8_0to15", 7, 0, 15, 1, 0, 0);
    run_case("k3_multi", 2, 20, 27, 2, 0, 0);
    run_case("one_point", $urandom_range(0, 7), 5, 5, 1, 0, 0);
    run_case("empty_range", 3, 10, 4, 1, 0, 0);
    run_case("two_points", 1, 100, 101, 2, 0, 0);
    run_case("pipe_points", 4, 7, 9, 1, 0, 0);
    run_case("iter_cap", $urandom_range(0, 7), 30, 40, 5, 3, 0);
    for (int r = 0; r < 6; r++) begin
      fa = $urandom_range(0, 400);
      la = fa + $urandom_range(0, 20);
      run_case($sformatf("rand%0d", r), $urandom_range(0, 7), fa, la,
               $urandom_range(1, 3), $urandom_range(0, 2), 0);
    end
    run_case("abort_classify", 5, 0, 9, 1, 0, 1);
    run_case("rst_conv_wait", 3, 50, 60, 10, 0, 2);
    run_case("after_rst", 3, 50, 60, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
KMEANS_ITER_CTRL -- requirements
Module: kmeans_iter_ctrl

Interface
REQ-001 SHALL have parameters:
- CENT_NUM, 8, maximum centroid count
- LOG2_CENT_NUM, 3, centroid index width
- ADDR_W, 9, RAM point-address width
- PIPE_DEPTH, 3, classification pipe latency in cycles (1..7)
- ITER_W, 8, iteration-counter width
- REG_W, 4, register-file index width
- CENT_REG_BASE, 2, register-file index of centroid 0
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- go  in  1  start pulse, sampled in IDLE only
- abort  in  1  terminate the run
- k_m1  in  LOG2_CENT_NUM  active centroids minus 1
- first_addr, last_addr  in  ADDR_W  inclusive point range
- max_iter  in  ITER_W  iteration cap
- conv_valid, has_converged  in  1  convergence result strobe and value
- reg_num  out  REG_W  register-file index
- reg_write  out  1  register-file write strobe
- cent_en  out  CENT_NUM  one-hot centroid-register enable
- ram_addr  out  ADDR_W  RAM address
- ram_cs_n, ram_oe_n  out  1  RAM chip select and output enable, active-low
- acc_en, pipe_clr, first_iter, div_en, conv_en, conv_clr  out  1  datapath controls
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- status  out  2  00 none, 01 converged, 10 iteration cap, 11 aborted
- iter_cnt  out  ITER_W  completed iterations

Function
REQ-003 SHALL implement states IDLE, LOAD_CENT, FILL, CLASSIFY, DRAIN, CALC, CONV_WAIT, WRITEBACK, DONE, with all outputs registered.
REQ-004 IDLE->LOAD_CENT on go; latch k_m1, first_addr, last_addr, max_iter; clear iter_cnt and status; raise busy.
REQ-005 LOAD_CENT: for i=0..k_m1, one cycle each: reg_num=CENT_REG_BASE+i, next cycle cent_en=1<<i; first_iter=1; then FILL.
REQ-006 FILL: ram_cs_n=0, ram_oe_n=0, ram_addr from first_addr incrementing each cycle; pipe_clr=1 on the first FILL cycle only; stay PIPE_DEPTH cycles; then CLASSIFY.
REQ-007 CLASSIFY: acc_en=1; ram_addr increments each cycle; after the cycle issuing last_addr go to DRAIN.
REQ-008 FILL SHALL exit to DRAIN when last_addr is issued before PIPE_DEPTH cycles elapse, i.e. when the range is shorter than the pipe.
REQ-009 DRAIN: ram_cs_n=ram_oe_n=1; acc_en=1 for exactly PIPE_DEPTH cycles; then CALC.
REQ-010 CALC: acc_en=0, div_en=1, conv_clr=1 for one cycle; then CONV_WAIT.
REQ-011 CONV_WAIT: conv_en=1; cent_en walks one-hot from bit 0 to bit k_m1, one bit per cycle, then 0; wait for conv_valid; iter_cnt increments on conv_valid.
REQ-012 On conv_valid: has_converged=1 -> status=01, WRITEBACK; else -> FILL with first_iter=0 and ram_addr reloaded to first_addr.
REQ-013 first_addr>last_addr SHALL go straight from LOAD_CENT to DONE with status=11.
REQ-014 WRITEBACK: reg_write=1 and reg_num=CENT_REG_BASE+i for i=0..k_m1, one per cycle; then DONE.
REQ-015 DONE: done=1 for one cycle, busy=0, div_en=0; then IDLE; status and iter_cnt hold until next go.
REQ-016 abort in any non-IDLE state: next state DONE, status=11, all RAM/datapath strobes deasserted; abort takes priority over conv_valid in the same cycle.
REQ-017 go while busy SHALL be ignored.
REQ-018 iter_cnt SHALL saturate at all-ones and not wrap.

Reset
REQ-019 rst SHALL asynchronously force IDLE; outputs 0, except ram_cs_n=ram_oe_n=1 and first_iter=1.
REQ-020 rst mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-021 Macro KMEANS_ITER_LIMIT_EN defined: on a non-converged conv_valid with iter_cnt+1==max_iter (max_iter=0 means unlimited), go to WRITEBACK with status=10. Macro undefined: max_iter ignored, iteration runs until convergence or abort.

Verification
REQ-022 k_m1=7, range 0..15, converge after 1st iteration -> 8 LOAD writes, 8 WRITEBACK writes reg_num 2..9, status=01, iter_cnt=1.
REQ-023 k_m1=2 -> cent_en shows only bits 0..2; WRITEBACK writes reg_num 2..4.
REQ-024 range 5..5 (1 point, PIPE_DEPTH=3) -> single ram_addr=5, DRAIN acc_en for 3 cycles.
REQ-025 KMEANS_ITER_LIMIT_EN, max_iter=3, never converge -> status=10, iter_cnt=3, done pulse.
REQ-026 abort during CLASSIFY -> DONE next cycle, status=11, ram_cs_n=1.
REQ-027 rst asserted in CONV_WAIT -> IDLE immediately, no done pulse; subsequent go runs normally.
